field_order_arbiter: RTL and testbench

- Merges the two encoded byte streams (varint path and raw-data path) into the single output byte FIFO read by the AXI read side.
- Bytes are emitted in ascending protobuf field index order.
- Once a field is started, all of its bytes are emitted contiguously.
- Sits between the varint/raw-data output FIFO pairs (byte FIFO plus index FIFO, show-ahead) and the output FIFO push port; it owns their pop strobes.

---
 rtl/serializer_pkg.sv | 20 ++
 rtl/field_order_arbiter.sv | 123 ++++++++++++
 tb/tb_field_order_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared types for the serializer output path: field/byte widths, the
// arbiter state encoding and the stream grant select.
package serializer_pkg;

    localparam int SER_IDX_W  = 10;
    localparam int SER_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VARINT = 2'd1,
        ST_RAW    = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        GNT_NONE   = 2'd0,
        GNT_VARINT = 2'd1,
        GNT_RAW    = 2'd2
    } grant_t;

endpackage

// File: rtl/field_order_arbiter.sv
// Merges the varint and raw-data byte streams into the output FIFO in
// ascending field-index order, keeping each field's bytes contiguous.
module field_order_arbiter
    import serializer_pkg::*;
#(
    parameter int IDX_W  = SER_IDX_W,
    parameter int DATA_W = SER_DATA_W,
    parameter int CNT_W  = 16
) (
    input  logic              clock_clk,
    input  logic              reset_reset,
    input  logic              soft_clr,
    input  logic              vi_empty,
    input  logic [DATA_W-1:0] vi_data,
    input  logic [IDX_W-1:0]  vi_index,
    input  logic              vi_encoding,
    output logic              vi_pop,
    input  logic              rd_empty,
    input  logic [DATA_W-1:0] rd_data,
    input  logic [IDX_W-1:0]  rd_index,
    input  logic              rd_encoding,
    output logic              rd_pop,
    input  logic              out_full,
    output logic              out_push,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [CNT_W-1:0]  byte_count,
    output logic [CNT_W-1:0]  field_count
);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_lock_idx;
    logic [CNT_W-1:0]   r_byte_count;
    logic [CNT_W-1:0]   r_field_count;

    logic   w_vi_elig;
    logic   w_rd_elig;
    logic   w_done;
    logic   w_hold;
    grant_t w_grant;

    // A stream may start only when the other one cannot still deliver a lower index.
    assign w_vi_elig = !vi_empty &&
                       ((rd_empty && !rd_encoding) || (!rd_empty && (vi_index <= rd_index)));
    assign w_rd_elig = !rd_empty &&
                       ((vi_empty && !vi_encoding) || (!vi_empty && (rd_index < vi_index)));

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_grant = GNT_NONE;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vi_elig)
                    w_grant = GNT_VARINT;
                else if (w_rd_elig)
                    w_grant = GNT_RAW;
            end
            ST_VARINT: begin
                w_grant = GNT_VARINT;
                w_done  = vi_empty ? !vi_encoding : (vi_index != r_lock_idx);
            end
            ST_RAW: begin
                w_grant = GNT_RAW;
                w_done  = rd_empty ? !rd_encoding : (rd_index != r_lock_idx);
            end
            default: begin
                w_grant = GNT_NONE;
                w_done  = 1'b0;
            end
        endcase
    end

    assign w_hold   = out_full | soft_clr | reset_reset;
    assign vi_pop   = !w_hold && (w_grant == GNT_VARINT) && !vi_empty && !w_done;
    assign rd_pop   = !w_hold && (w_grant == GNT_RAW) && !rd_empty && !w_done;
    assign out_push = vi_pop | rd_pop;
    assign out_data = (w_grant == GNT_VARINT) ? vi_data : rd_data;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of evaluation order.
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_state       <= ST_IDLE;
            r_lock_idx    <= '0;
            r_byte_count  <= '0;
            r_field_count <= '0;
        end else if (soft_clr) begin
            r_state       <= ST_IDLE;
            r_lock_idx    <= '0;
            r_byte_count  <= '0;
            r_field_count <= '0;
        end else begin
            if (out_push)
                r_byte_count <= r_byte_count + CNT_W'(1);
            if (!out_full) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_grant == GNT_VARINT) begin
                            r_state    <= ST_VARINT;
                            r_lock_idx <= vi_index;
                        end else if (w_grant == GNT_RAW) begin
                            r_state    <= ST_RAW;
                            r_lock_idx <= rd_index;
                        end
                    end
                    ST_VARINT, ST_RAW: begin
                        if (w_done) begin
                            r_state       <= ST_IDLE;
                            r_field_count <= r_field_count + CNT_W'(1);
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy        = (r_state != ST_IDLE) | !vi_empty | !rd_empty | vi_encoding | rd_encoding;
    assign byte_count  = r_byte_count;
    assign field_count = r_field_count;

endmodule

// File: tb/tb_field_order_arbiter.sv
// Self-checking bench: show-ahead FIFO models feed the arbiter and the pushed
// byte stream is compared with an index-ordered merge of the queued fields.
module tb_field_order_arbiter;

    typedef struct packed {
        logic [9:0] idx;
        logic [7:0] data;
    } ent_t;

    logic       clock_clk = 1'b0;
    logic       reset_reset;
    logic       soft_clr;
    logic       vi_empty, rd_empty;
    logic [7:0] vi_data, rd_data;
    logic [9:0] vi_index, rd_index;
    logic       vi_encoding, rd_encoding;
    logic       vi_pop, rd_pop;
    logic       out_full;
    logic       out_push;
    logic [7:0] out_data;
    logic       busy;
    logic [15:0] byte_count, field_count;

    int checks = 0;
    int failures = 0;
    int exp_bytes = 0;
    int exp_fields = 0;

    ent_t       vi_q[$];
    ent_t       rd_q[$];
    logic [7:0] got[$];
    logic [7:0] exp_seq[$];

    field_order_arbiter #(.IDX_W(10), .DATA_W(8), .CNT_W(16)) dut (
        .clock_clk(clock_clk), .reset_reset(reset_reset), .soft_clr(soft_clr),
        .vi_empty(vi_empty), .vi_data(vi_data), .vi_index(vi_index),
        .vi_encoding(vi_encoding), .vi_pop(vi_pop),
        .rd_empty(rd_empty), .rd_data(rd_data), .rd_index(rd_index),
        .rd_encoding(rd_encoding), .rd_pop(rd_pop),
        .out_full(out_full), .out_push(out_push), .out_data(out_data),
        .busy(busy), .byte_count(byte_count), .field_count(field_count)
    );

    always #5 clock_clk = ~clock_clk;

    task automatic drive_heads();
        vi_empty = (vi_q.size() == 0);
        vi_data  = vi_empty ? 8'h00 : vi_q[0].data;
        vi_index = vi_empty ? 10'd0 : vi_q[0].idx;
        rd_empty = (rd_q.size() == 0);
        rd_data  = rd_empty ? 8'h00 : rd_q[0].data;
        rd_index = rd_empty ? 10'd0 : rd_q[0].idx;
    endtask

    task automatic push_vi(input int idx, input logic [7:0] d);
        vi_q.push_back('{idx: 10'(idx), data: d});
    endtask

    task automatic push_rd(input int idx, input logic [7:0] d);
        rd_q.push_back('{idx: 10'(idx), data: d});
    endtask

    function automatic string q2s(input logic [7:0] q[$]);
        string s = "";
        foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
        return s;
    endfunction

    // Reference: repeatedly take the whole leading field of whichever stream has
    // the lower head index (varint on ties), as the merge order demands.
    task automatic model_merge(input ent_t a_in[$], input ent_t b_in[$],
                               output logic [7:0] seq[$], output int nfields);
        ent_t a[$];
        ent_t b[$];
        logic [9:0] f;
        bit take_a;
        a = a_in;
        b = b_in;
        seq.delete();
        nfields = 0;
        while (a.size() > 0 || b.size() > 0) begin
            if (a.size() == 0)      take_a = 1'b0;
            else if (b.size() == 0) take_a = 1'b1;
            else                    take_a = (a[0].idx <= b[0].idx);
            if (take_a) begin
                f = a[0].idx;
                while (a.size() > 0 && a[0].idx == f) seq.push_back(a.pop_front().data);
            end else begin
                f = b[0].idx;
                while (b.size() > 0 && b[0].idx == f) seq.push_back(b.pop_front().data);
            end
            nfields++;
        end
    endtask

    // Entered and left at posedge+2 with inputs settled.
    task automatic cycle();
        logic s_vi, s_rd;
        s_vi = vi_pop;
        s_rd = rd_pop;
        checks++;
        if ((s_vi && s_rd) || (out_push !== (s_vi | s_rd)) ||
            (s_vi && vi_q.size() == 0) || (s_rd && rd_q.size() == 0) ||
            (out_full && out_push)) begin
            failures++;
            $display("FAIL pop_rules: vi_pop=%b rd_pop=%b out_push=%b out_full=%b vi_n=%0d rd_n=%0d",
                     s_vi, s_rd, out_push, out_full, vi_q.size(), rd_q.size());
        end
        if (out_push) got.push_back(out_data);
        @(posedge clock_clk);
        #1;
        if (s_vi && vi_q.size() > 0) void'(vi_q.pop_front());
        if (s_rd && rd_q.size() > 0) void'(rd_q.pop_front());
        drive_heads();
        #1;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            cycle();
            n++;
        end
        checks++;
        if (busy) begin
            failures++;
            $display("FAIL drain_timeout: busy still %b after %0d cycles", busy, budget);
        end
    endtask

    task automatic check_counts(input string name);
        checks++;
        if (byte_count !== 16'(exp_bytes) || field_count !== 16'(exp_fields)) begin
            failures++;
            $display("FAIL %s_counts: byte_count=%0d field_count=%0d expected %0d/%0d",
                     name, byte_count, field_count, 16'(exp_bytes), 16'(exp_fields));
        end
    endtask

    task automatic check_seq(input string name);
        checks++;
        if (q2s(got) != q2s(exp_seq)) begin
            failures++;
            $display("FAIL %s_seq: got [%s] expected [%s]", name, q2s(got), q2s(exp_seq));
        end
    endtask

    task automatic test_reset();
        reset_reset = 1'b1; soft_clr = 1'b0; out_full = 1'b0;
        vi_encoding = 1'b0; rd_encoding = 1'b0;
        vi_q.delete(); rd_q.delete();
        drive_heads();
        #2;
        checks++;
        if (out_push !== 1'b0 || vi_pop !== 1'b0 || rd_pop !== 1'b0 || busy !== 1'b0 ||
            byte_count !== 16'd0 || field_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_state: push=%b vi_pop=%b rd_pop=%b busy=%b bytes=%0d fields=%0d expected all 0",
                     out_push, vi_pop, rd_pop, busy, byte_count, field_count);
        end
        @(negedge clock_clk) reset_reset = 1'b0;
        @(posedge clock_clk);
        #2;
    endtask

    task automatic test_basic_order();
        got.delete();
        push_vi(1, 8'h96); push_vi(1, 8'h01);
        push_rd(2, 8'h41); push_rd(2, 8'h42);
        drive_heads(); #1;
        drain(20);
        exp_seq = '{8'h96, 8'h01, 8'h41, 8'h42};
        exp_bytes += 4; exp_fields += 2;
        check_seq("basic_order");
        check_counts("basic_order");
    endtask

    task automatic test_wait_lower();
        got.delete();
        push_rd(3, 8'hA0); push_rd(3, 8'hA1);
        vi_encoding = 1'b1;
        drive_heads(); #1;
        repeat (5) cycle();
        checks++;
        if (got.size() != 0) begin
            failures++;
            $display("FAIL wait_lower_hold: %0d bytes pushed while varint encoding, expected 0", got.size());
        end
        push_vi(2, 8'h08);
        vi_encoding = 1'b0;
        drive_heads(); #1;
        drain(20);
        exp_seq = '{8'h08, 8'hA0, 8'hA1};
        exp_bytes += 3; exp_fields += 2;
        check_seq("wait_lower");
        check_counts("wait_lower");
    endtask

    task automatic test_field_continue();
        got.delete();
        rd_encoding = 1'b1;
        push_rd(5, 8'hC0); push_rd(5, 8'hC1);
        push_vi(7, 8'hD0);
        drive_heads(); #1;
        repeat (4) cycle();
        exp_seq = '{8'hC0, 8'hC1};
        check_seq("field_stall");
        push_rd(5, 8'hC2);
        rd_encoding = 1'b0;
        drive_heads(); #1;
        drain(20);
        exp_seq = '{8'hC0, 8'hC1, 8'hC2, 8'hD0};
        exp_bytes += 4; exp_fields += 2;
        check_seq("field_continue");
        check_counts("field_continue");
    endtask

    task automatic test_out_full();
        got.delete();
        for (int i = 0; i < 4; i++) push_vi(6, 8'hE0 + 8'(i));
        drive_heads(); #1;
        cycle(); cycle();
        out_full = 1'b1; #1;
        repeat (4) cycle();
        checks++;
        if (got.size() != 2 || vi_q.size() != 2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL out_full_hold: pushed=%0d left=%0d busy=%b expected 2/2/1",
                     got.size(), vi_q.size(), busy);
        end
        out_full = 1'b0; #1;
        drain(20);
        exp_seq = '{8'hE0, 8'hE1, 8'hE2, 8'hE3};
        exp_bytes += 4; exp_fields += 1;
        check_seq("out_full");
        check_counts("out_full");
    endtask

    task automatic test_equal_idx();
        got.delete();
        push_vi(4, 8'h11); push_vi(4, 8'h12);
        push_rd(4, 8'h21); push_rd(4, 8'h22);
        drive_heads(); #1;
        drain(20);
        exp_seq = '{8'h11, 8'h12, 8'h21, 8'h22};
        exp_bytes += 4; exp_fields += 2;
        check_seq("equal_idx");
        check_counts("equal_idx");
    endtask

    task automatic test_clear_and_reset();
        got.delete();
        for (int i = 0; i < 4; i++) push_vi(9, 8'h31 + 8'(i));
        drive_heads(); #1;
        cycle(); cycle();
        soft_clr = 1'b1; #1;
        checks++;
        if (out_push !== 1'b0 || vi_pop !== 1'b0 || rd_pop !== 1'b0) begin
            failures++;
            $display("FAIL soft_clr_push: push=%b vi_pop=%b rd_pop=%b expected 0",
                     out_push, vi_pop, rd_pop);
        end
        cycle();
        soft_clr = 1'b0; #1;
        exp_bytes = 0; exp_fields = 0;
        check_counts("soft_clr");
        drain(20);
        exp_seq = '{8'h31, 8'h32, 8'h33, 8'h34};
        exp_bytes = 2; exp_fields = 1;
        check_seq("soft_clr");
        check_counts("after_clr");

        push_vi(12, 8'h41); push_vi(12, 8'h42); push_vi(12, 8'h43);
        drive_heads(); #1;
        cycle();
        #2;
        reset_reset = 1'b1;
        #1;
        checks++;
        if (byte_count !== 16'd0 || field_count !== 16'd0 || out_push !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: bytes=%0d fields=%0d push=%b expected 0/0/0",
                     byte_count, field_count, out_push);
        end
        vi_q.delete();
        drive_heads();
        @(negedge clock_clk) reset_reset = 1'b0;
        @(posedge clock_clk);
        #2;
        exp_bytes = 0; exp_fields = 0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b expected 0", busy);
        end
        check_counts("after_reset");
    endtask

    task automatic test_random();
        int nf;
        int n;
        int prev;
        int idx;
        for (int it = 0; it < 30; it++) begin
            got.delete();
            for (int s = 0; s < 2; s++) begin
                prev = -1;
                for (int r = 0; r < int'($urandom_range(0, 3)); r++) begin
                    do idx = int'($urandom_range(0, 7)); while (idx == prev);
                    prev = idx;
                    for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
                        if (s == 0) push_vi(idx, 8'($urandom));
                        else        push_rd(idx, 8'($urandom));
                    end
                end
            end
            model_merge(vi_q, rd_q, exp_seq, nf);
            exp_bytes += exp_seq.size();
            exp_fields += nf;
            drive_heads(); #1;
            n = 0;
            while (n < 200) begin
                out_full = ($urandom_range(0, 3) == 0);
                #1;
                if (!busy) break;
                cycle();
                n++;
            end
            out_full = 1'b0; #1;
            drain(50);
            check_seq($sformatf("random%0d", it));
            check_counts($sformatf("random%0d", it));
        end
    endtask

    initial begin
        test_reset();
        test_basic_order();
        test_wait_lower();
        test_field_continue();
        test_out_full();
        test_equal_idx();
        test_clear_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
